// File: rtl/sysctrl_irq_pkg.sv
// -----------------------------------------------------------------------------
// sysctrl_irq_pkg
// Shared definitions for the system-control IRQ capture block: line mode
// encoding, default sizing parameters, and the mapping of CPU IRQ numbers
// to line indices.
// -----------------------------------------------------------------------------
package sysctrl_irq_pkg;

   // Per-line qualification mode as driven on irq_mode_i.
   typedef enum logic {
      IRQ_MODE_EDGE  = 1'b0,   // latch on rising edge of the synchronized pad
      IRQ_MODE_LEVEL = 1'b1    // latch while the synchronized pad is high
   } irq_mode_e;

   // Default sizing.
   localparam int unsigned DEF_NUM_IRQ     = 2;
   localparam int unsigned DEF_SYNC_STAGES = 2;   // legal range 2..4
   localparam int unsigned DEF_CNT_W       = 8;

   // Line index of each CPU interrupt input.
   localparam int unsigned IRQ7_IDX = 0;
   localparam int unsigned IRQ8_IDX = 1;

endpackage : sysctrl_irq_pkg

// File: rtl/sysctrl_irq_line.sv
// -----------------------------------------------------------------------------
// sysctrl_irq_line
// One interrupt line: pad synchronizer, edge/level qualifier, pending flag,
// overrun flag and saturating event counter.
//
// Ports:
//   wb_clk_i   system clock
//   wb_rst_i   synchronous active-high reset
//   en_i       line enable (gates set and count events only)
//   mode_i     0 = rising edge, 1 = level high
//   pin_i      raw asynchronous pad input
//   clr_i      one-cycle clear of pending and overrun
//   cnt_clr_i  one-cycle clear of the event counter
//   irq_o      pending flag
//   ovr_o      overrun flag
//   cnt_o      saturating event counter
// -----------------------------------------------------------------------------
module sysctrl_irq_line
   import sysctrl_irq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             en_i,
   input  logic             mode_i,
   input  logic             pin_i,
   input  logic             clr_i,
   input  logic             cnt_clr_i,
   output logic             irq_o,
   output logic             ovr_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   pend_q, pend_d;
   logic                   ovr_q,  ovr_d;
   logic [CNT_W-1:0]       cnt_q,  cnt_d;

   logic sync;
   logic rise;
   logic edge_mode;
   logic set_evt;
   logic cnt_evt;

   always_comb begin
      // NOTE: every _d gets a default (hold) first so no path leaves it unassigned and no latch is inferred.
      sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_d = prev_q;
      pend_d = pend_q;
      ovr_d  = ovr_q;
      cnt_d  = cnt_q;

      // The synchronizer and prev sample free-run independent of the enable,
      // so enabling a line whose pad is already high sees no edge.
      sync      = sync_q[SYNC_STAGES-1];
      prev_d    = sync;
      rise      = sync & ~prev_q;
      edge_mode = (irq_mode_e'(mode_i) == IRQ_MODE_EDGE);

      // Level mode re-asserts set every cycle the line is high, which is what
      // makes a clear ineffective until the pad drops. Only the rising edge
      // is counted in either mode.
      set_evt = en_i & (edge_mode ? rise : sync);
      cnt_evt = en_i & rise;

      // Overrun uses the pending flag before this cycle's update; a clear in
      // the same cycle acknowledges the earlier event, so no overrun.
      if (set_evt && pend_q && !clr_i && edge_mode) begin
         ovr_d = 1'b1;
      end else if (clr_i) begin
         ovr_d = 1'b0;
      end

      // Set wins over clear so an event coinciding with a clear is not lost.
      if (set_evt) begin
         pend_d = 1'b1;
      end else if (clr_i) begin
         pend_d = 1'b0;
      end

      if (cnt_clr_i) begin
         cnt_d = cnt_evt ? CNT_ONE : '0;
      end else if (cnt_evt && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign irq_o = pend_q;
   assign ovr_o = ovr_q;
   assign cnt_o = cnt_q;

endmodule : sysctrl_irq_line

// File: rtl/sysctrl_irq_capture.sv
// -----------------------------------------------------------------------------
// sysctrl_irq_capture
// Captures asynchronous pad interrupts into pending flags for the CPU, gated
// by the IRQ_SRC enables of the system-control register block. Line 0 feeds
// IRQ7, line 1 feeds IRQ8. Lines are fully independent.
//
// Ports:
//   wb_clk_i      system clock (only clock)
//   wb_rst_i      synchronous active-high reset
//   irq_src_en_i  per-line enable from IRQ_SRC
//   irq_mode_i    per-line mode: 0 = rising edge, 1 = level high
//   irq_pin_i     raw asynchronous pad inputs
//   irq_clr_i     per-line clear pulses for pending and overrun
//   cnt_clr_i     per-line clear pulses for the event counters
//   irq_o         pending flags
//   irq_ovr_o     overrun flags
//   irq_cnt_o     flattened counters, line i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module sysctrl_irq_capture
   import sysctrl_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = DEF_NUM_IRQ,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [NUM_IRQ-1:0]       irq_src_en_i,
   input  logic [NUM_IRQ-1:0]       irq_mode_i,
   input  logic [NUM_IRQ-1:0]       irq_pin_i,
   input  logic [NUM_IRQ-1:0]       irq_clr_i,
   input  logic [NUM_IRQ-1:0]       cnt_clr_i,
   output logic [NUM_IRQ-1:0]       irq_o,
   output logic [NUM_IRQ-1:0]       irq_ovr_o,
   output logic [NUM_IRQ*CNT_W-1:0] irq_cnt_o
);

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
      sysctrl_irq_line #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_line (
         .wb_clk_i  (wb_clk_i),
         .wb_rst_i  (wb_rst_i),
         .en_i      (irq_src_en_i[i]),
         .mode_i    (irq_mode_i[i]),
         .pin_i     (irq_pin_i[i]),
         .clr_i     (irq_clr_i[i]),
         .cnt_clr_i (cnt_clr_i[i]),
         .irq_o     (irq_o[i]),
         .ovr_o     (irq_ovr_o[i]),
         .cnt_o     (irq_cnt_o[i*CNT_W +: CNT_W])
      );
   end

endmodule : sysctrl_irq_capture

// File: tb/tb_sysctrl_irq_capture.sv
// -----------------------------------------------------------------------------
// tb_sysctrl_irq_capture
// Scoreboard bench: every clock the stimulus process advances a reference
// model (pad sample history, pending/overrun flags, integer event counts) and
// queues the expected outputs; a monitor pops one entry per clock and
// compares it with the DUT. Directed scenarios add explicit constant checks,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sysctrl_irq_capture;
   import sysctrl_irq_pkg::*;

   localparam int NUM = 2;
   localparam int SS  = 2;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i = 1'b1;
   logic [NUM-1:0]    irq_src_en_i = '0;
   logic [NUM-1:0]    irq_mode_i   = '0;
   logic [NUM-1:0]    irq_pin_i    = '0;
   logic [NUM-1:0]    irq_clr_i    = '0;
   logic [NUM-1:0]    cnt_clr_i    = '0;
   logic [NUM-1:0]    irq_o;
   logic [NUM-1:0]    irq_ovr_o;
   logic [NUM*CW-1:0] irq_cnt_o;

   sysctrl_irq_capture #(
      .NUM_IRQ     (NUM),
      .SYNC_STAGES (SS),
      .CNT_W       (CW)
   ) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .irq_src_en_i (irq_src_en_i),
      .irq_mode_i   (irq_mode_i),
      .irq_pin_i    (irq_pin_i),
      .irq_clr_i    (irq_clr_i),
      .cnt_clr_i    (cnt_clr_i),
      .irq_o        (irq_o),
      .irq_ovr_o    (irq_ovr_o),
      .irq_cnt_o    (irq_cnt_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [NUM-1:0]    irq;
      logic [NUM-1:0]    ovr;
      logic [NUM*CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   bit m_hist [NUM][SS+1];   // m_hist[i][k] = pad sampled k+1 clocks ago
   bit m_pend [NUM];
   bit m_ovr  [NUM];
   int m_cnt  [NUM];

   // Applies the effect of one clock edge with the currently driven inputs.
   task automatic model_step();
      exp_t e;
      for (int i = 0; i < NUM; i++) begin
         bit seen_now, seen_before, risen, enabled, level, latch_evt, count_evt;
         if (wb_rst_i) begin
            for (int k = 0; k <= SS; k++) m_hist[i][k] = 1'b0;
            m_pend[i] = 1'b0;
            m_ovr[i]  = 1'b0;
            m_cnt[i]  = 0;
         end else begin
            // The synchronized value lags the pad by SS samples.
            seen_now    = m_hist[i][SS-1];
            seen_before = m_hist[i][SS];
            risen       = seen_now && !seen_before;
            enabled     = irq_src_en_i[i];
            level       = irq_mode_i[i];
            latch_evt   = enabled && (level ? seen_now : risen);
            count_evt   = enabled && risen;
            // A fresh edge on an unacknowledged edge-mode interrupt is an overrun.
            if (!level && latch_evt && m_pend[i] && !irq_clr_i[i]) m_ovr[i] = 1'b1;
            else if (irq_clr_i[i]) m_ovr[i] = 1'b0;
            if (latch_evt) m_pend[i] = 1'b1;
            else if (irq_clr_i[i]) m_pend[i] = 1'b0;
            if (cnt_clr_i[i]) m_cnt[i] = count_evt ? 1 : 0;
            else if (count_evt && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            for (int k = SS; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = irq_pin_i[i];
         end
         e.irq[i] = m_pend[i];
         e.ovr[i] = m_ovr[i];
         e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
      end
      exp_q.push_back(e);
   endtask

   // One clock: model follows the edge; returns at the falling edge, where
   // inputs are changed and explicit checks are made.
   task automatic tick(input int n = 1);
      for (int j = 0; j < n; j++) begin
         @(posedge wb_clk_i);
         model_step();
         @(negedge wb_clk_i);
      end
   endtask

   // ---------------- monitor ----------------
   exp_t mon_e;
   always @(posedge wb_clk_i) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("sb_irq_o", 32'(irq_o), 32'(mon_e.irq));
         check("sb_irq_ovr_o", 32'(irq_ovr_o), 32'(mon_e.ovr));
         check("sb_irq_cnt_o", 32'(irq_cnt_o), 32'(mon_e.cnt));
      end
   end

   function automatic logic [CW-1:0] cnt_of(input int i);
      return irq_cnt_o[i*CW +: CW];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam int L7 = IRQ7_IDX;
   localparam int L8 = IRQ8_IDX;

   initial begin
      // Reset
      tick(2);
      wb_rst_i = 1'b0;
      tick();
      check("reset_irq", 32'(irq_o), 0);
      check("reset_ovr", 32'(irq_ovr_o), 0);
      check("reset_cnt", 32'(irq_cnt_o), 0);

      // 1: latency of an edge-mode event
      irq_src_en_i = 2'b11;
      irq_mode_i   = 2'b00;
      irq_pin_i[L7] = 1'b1;
      tick();
      check("lat_clk1", 32'(irq_o), 0);
      tick();
      check("lat_clk2", 32'(irq_o), 0);
      tick();
      check("lat_clk3", 32'(irq_o), 32'b01);
      tick();
      irq_pin_i[L7] = 1'b0;
      tick(3);
      check("p1_cnt0", 32'(cnt_of(L7)), 1);
      check("p1_cnt1", 32'(cnt_of(L8)), 0);

      // 2: second edge while pending -> overrun, then clear
      irq_pin_i[L7] = 1'b1;
      tick(3);
      irq_pin_i[L7] = 1'b0;
      tick(3);
      check("p2_ovr", 32'(irq_ovr_o[L7]), 1);
      check("p2_cnt0", 32'(cnt_of(L7)), 2);
      irq_clr_i[L7] = 1'b1;
      tick();
      irq_clr_i[L7] = 1'b0;
      check("p2_clr_irq", 32'(irq_o[L7]), 0);
      check("p2_clr_ovr", 32'(irq_ovr_o[L7]), 0);

      // 3: clear coinciding with a qualified edge while pending
      irq_pin_i[L7] = 1'b1;
      tick(3);
      irq_pin_i[L7] = 1'b0;
      tick(3);
      irq_pin_i[L7] = 1'b1;
      tick(2);
      irq_clr_i[L7] = 1'b1;
      tick();
      irq_clr_i[L7] = 1'b0;
      check("p3_irq", 32'(irq_o[L7]), 1);
      check("p3_ovr", 32'(irq_ovr_o[L7]), 0);
      check("p3_cnt0", 32'(cnt_of(L7)), 4);
      irq_pin_i[L7] = 1'b0;
      tick(3);
      irq_clr_i[L7] = 1'b1;
      tick();
      irq_clr_i[L7] = 1'b0;

      // 4: level mode holds pending against clears while the pad is high
      irq_mode_i[L8] = 1'b1;
      irq_pin_i[L8]  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         irq_clr_i[L8] = k[0];
         tick();
      end
      irq_clr_i[L8] = 1'b0;
      check("p4_irq_held", 32'(irq_o[L8]), 1);
      check("p4_cnt1", 32'(cnt_of(L8)), 1);
      check("p4_no_ovr", 32'(irq_ovr_o[L8]), 0);
      irq_pin_i[L8] = 1'b0;
      tick(3);
      irq_clr_i[L8] = 1'b1;
      tick();
      irq_clr_i[L8] = 1'b0;
      check("p4_irq_clr", 32'(irq_o[L8]), 0);
      irq_mode_i[L8] = 1'b0;

      // 5: disabled line ignores toggles; enabling with pad high is silent
      irq_src_en_i[L7] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         irq_pin_i[L7] = 1'b1;
         tick(2);
         irq_pin_i[L7] = 1'b0;
         tick(2);
      end
      irq_pin_i[L7] = 1'b1;
      tick(3);
      irq_src_en_i[L7] = 1'b1;
      tick(3);
      check("p5_irq", 32'(irq_o[L7]), 0);
      check("p5_cnt0", 32'(cnt_of(L7)), 4);
      irq_pin_i[L7] = 1'b0;
      tick(3);

      // 6: saturation, clear-with-event, reset mid-burst
      for (int k = 0; k < 20; k++) begin
         irq_pin_i[L7] = 1'b1;
         tick();
         irq_pin_i[L7] = 1'b0;
         tick();
      end
      tick(3);
      check("p6_sat", 32'(cnt_of(L7)), CMAX);
      irq_pin_i[L7] = 1'b1;
      tick(2);
      cnt_clr_i[L7] = 1'b1;
      tick();
      cnt_clr_i[L7] = 1'b0;
      check("p6_clr_evt", 32'(cnt_of(L7)), 1);
      irq_pin_i[L7] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         irq_pin_i = ~irq_pin_i;
         tick();
      end
      wb_rst_i = 1'b1;
      irq_pin_i = ~irq_pin_i;
      tick();
      check("p6_rst_irq", 32'(irq_o), 0);
      check("p6_rst_ovr", 32'(irq_ovr_o), 0);
      check("p6_rst_cnt", 32'(irq_cnt_o), 0);
      wb_rst_i = 1'b0;

      // Randomized phase
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NUM; i++) begin
            if ($urandom_range(2) == 0)  irq_pin_i[i]    = ~irq_pin_i[i];
            if ($urandom_range(19) == 0) irq_src_en_i[i] = ~irq_src_en_i[i];
            if ($urandom_range(29) == 0) irq_mode_i[i]   = ~irq_mode_i[i];
            irq_clr_i[i] = ($urandom_range(7) == 0);
            cnt_clr_i[i] = ($urandom_range(15) == 0);
         end
         wb_rst_i = ($urandom_range(249) == 0);
         tick();
      end
      wb_rst_i  = 1'b0;
      irq_clr_i = '0;
      cnt_clr_i = '0;
      tick(2);
      @(posedge wb_clk_i);
      #3;
      check("sb_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sysctrl_irq_capture

// File: doc/sysctrl_irq_capture.md
Name: sysctrl_irq_capture

Overview:
Downstream consumer of the system-control Wishbone register block's IRQ_SRC outputs.
- Takes per-line source enables from IRQ_SRC (bit 0 drives IRQ7, bit 1 drives IRQ8) and raw asynchronous pad inputs.
- Synchronizes, edge- or level-qualifies and latches each line into a pending flag for the CPU.
- Counts events per line and flags overrun.
- Sits between the pad/GPIO domain and the CPU IRQ inputs.

Parameters:
- NUM_IRQ, 2: number of interrupt lines (index 0 = IRQ7, 1 = IRQ8).
- SYNC_STAGES, 2: synchronizer flops per line; legal range 2..4.
- CNT_W, 8: width of each per-line saturating event counter.

Ports:
- wb_clk_i  input  1  system clock; the only clock.
- wb_rst_i  input  1  synchronous active-high reset.
- irq_src_en_i  input  NUM_IRQ  per-line enable, from the sysctrl IRQ_SRC register.
- irq_mode_i  input  NUM_IRQ  per-line mode: 0 = rising edge, 1 = level high.
- irq_pin_i  input  NUM_IRQ  raw asynchronous pad inputs.
- irq_clr_i  input  NUM_IRQ  one-cycle clear pulses for pending and overrun.
- cnt_clr_i  input  NUM_IRQ  one-cycle clear pulses for the event counters.
- irq_o  output  NUM_IRQ  pending flags to the CPU.
- irq_ovr_o  output  NUM_IRQ  overrun flags.
- irq_cnt_o  output  NUM_IRQ*CNT_W  flattened counters; line i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Clock and reset: single clock wb_clk_i; reset is synchronous and active-high on wb_rst_i.
- Reset values: all synchronizer flops, the prev-sample flop, irq_o, irq_ovr_o and irq_cnt_o are 0.
- Synchronizer:
  - Runs every cycle regardless of enable.
  - sync = last stage. prev = sync delayed by 1 cycle, also updated regardless of enable.
  - Enabling a line whose pad is already high therefore produces no spurious edge.
- Set event (per line), qualified by irq_src_en_i:
  - Edge mode: evt = en & sync & ~prev.
  - Level mode: set = en & sync on every cycle; the count event is only the rising edge en & sync & ~prev.
- Latency: pad rising edge sampled at clock n → irq_o high after clock n+SYNC_STAGES. With defaults, it is visible 3 clocks after first sampling.
- Pending:
  - set has priority over irq_clr_i in the same cycle; no event is lost.
  - Level mode while the line is still high: clear has no effect.
  - Deasserting the enable does not clear pending; only irq_clr_i or reset clears it.
- Overrun:
  - Sets when set-event & irq_o & ~irq_clr_i (edge mode only; level mode never flags overrun).
  - irq_clr_i clears irq_ovr_o.
  - Simultaneous clr + evt: pending = 1, overrun = 0.
- Counter:
  - +1 per count event; saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr_i with no event → 0. Simultaneous cnt_clr_i and event → 1.
  - irq_clr_i does not affect the counter.
- Mode change mid-operation:
  - Takes effect the next cycle.
  - Pending state is retained.
- Reset mid-operation: all state returns to its reset value on the next clock edge. Pad state is re-synchronized from scratch.
- Lines are fully independent; no cross-line interaction.

Decomposition:
- Package sysctrl_irq_pkg holds:
  - IRQ_MODE_EDGE = 1'b0, IRQ_MODE_LEVEL = 1'b1;
  - default NUM_IRQ, SYNC_STAGES, CNT_W;
  - IRQ7_IDX = 0, IRQ8_IDX = 1.
- One sub-module, sysctrl_irq_line: synchronizer, qualifier, pending, overrun and counter for one line.
- Top level: generate loop over NUM_IRQ plus flattening of the counter bus.

Test Plan:
1. Reset, en = 2'b11, mode = 0: pulse irq_pin_i[0] high for 4 clocks.
   - irq_o = 2'b01 exactly 3 clocks after first sampling.
   - cnt[0] = 1; cnt[1] = 0.
2. With irq_o[0] pending, a second edge on pin 0.
   - irq_ovr_o[0] = 1 and cnt[0] = 2.
   - Then irq_clr_i[0] → irq_o[0] = 0 and irq_ovr_o[0] = 0.
3. Assert irq_clr_i[0] in the same cycle as the qualified edge.
   - irq_o[0] = 1, irq_ovr_o[0] = 0.
4. Line 1 in level mode with pin held high for 20 clocks while pulsing irq_clr_i[1].
   - irq_o[1] stays 1 and cnt[1] = 1.
   - After the pin drops, one clear → irq_o[1] = 0.
5. en[0] = 0 with the pin toggled 5 times: irq_o[0] = 0, cnt[0] unchanged.
   - Then set en[0] = 1 while the pin is high: no event.
6. CNT_W = 4: apply 20 edges → cnt = 15 (saturated).
   - cnt_clr_i together with an edge → cnt = 1.
   - Assert wb_rst_i mid-burst → all outputs 0 on the next clock.
